// File: rtl/mesm6_bus_arbiter.sv
// mesm6_bus_arbiter: merges the core's instruction bus and data bus onto one
// single-port memory channel (req/ack). One access in flight at a time,
// round-robin between buses when both ask, watchdog abort on a missing ack.
module mesm6_bus_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 48,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // A zero-width counter is not legal, so a disabled watchdog keeps one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic OWN_IBUS = 1'b0;
  localparam logic OWN_DBUS = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;

  logic ibus_pend, dbus_pend, grant_dbus;

  assign ibus_pend = ibus_fetch;
  assign dbus_pend = dbus_read | dbus_write;

  // Next-state logic: arbitration in IDLE, ack/watchdog handling in ACCESS.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    grant_dbus   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ibus_pend || dbus_pend) begin
          // dbus wins when alone, or when both ask and ibus had the last turn.
          grant_dbus   = dbus_pend && (!ibus_pend || (last_grant_q == OWN_IBUS));
          owner_d      = grant_dbus ? OWN_DBUS : OWN_IBUS;
          last_grant_d = grant_dbus ? OWN_DBUS : OWN_IBUS;
          addr_d       = grant_dbus ? dbus_addr : ibus_addr;
          we_d         = grant_dbus & dbus_write;
          wdata_d      = dbus_output;
          cnt_d        = '0;
          err_d        = 1'b0;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          if (!we_q) begin
            if (owner_q == OWN_DBUS) drdata_d = mem_rdata;
            else                     irdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          // Aborted reads return zero so the core never sees stale data.
          if (!we_q) begin
            if (owner_q == OWN_DBUS) drdata_d = '0;
            else                     irdata_d = '0;
          end
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // Requests are ignored here: the core still shows the finished one.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Access, watchdog and read-hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWN_IBUS;
      last_grant_q <= OWN_IBUS;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
    end
  end

  assign mem_req    = (state_q == S_ACCESS);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ibus_input = irdata_q;
  assign dbus_input = drdata_q;
  assign ibus_done  = (state_q == S_DONE) && (owner_q == OWN_IBUS);
  assign dbus_done  = (state_q == S_DONE) && (owner_q == OWN_DBUS);
  assign bus_error  = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_mesm6_bus_arbiter.sv
// Directed bench for mesm6_bus_arbiter (watchdog shortened to 4 cycles).
module tb_mesm6_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read, dbus_write;
  logic [14:0] dbus_addr;
  logic [47:0] dbus_output, dbus_input;
  logic        dbus_done;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        bus_error;

  int checks = 0;
  int failures = 0;

  localparam logic [47:0] I1_VAL = 48'hA5A5_0000_0001;
  localparam logic [47:0] D_VAL  = 48'h1111_2222_3333;
  localparam logic [47:0] I_VAL  = 48'h4444_5555_6666;

  mesm6_bus_arbiter #(.ADDR_W(15), .DATA_W(48), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; ibus_fetch = 0; dbus_read = 0; dbus_write = 0; mem_ack = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ibus_addr = '0; dbus_addr = '0; dbus_output = '0; mem_rdata = '0;
    apply_reset();
    checks++; if ({mem_req, mem_we, ibus_done, dbus_done, bus_error} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000", {mem_req, mem_we, ibus_done, dbus_done, bus_error}); end
    checks++; if ({ibus_input, dbus_input} !== 96'h0) begin
      failures++; $display("FAIL reset_rdata ibus=%h dbus=%h want=0", ibus_input, dbus_input); end
    checks++; if ({mem_addr, mem_wdata} !== 63'h0) begin
      failures++; $display("FAIL reset_mem addr=%h wdata=%h want=0", mem_addr, mem_wdata); end
    $display("test_reset done");
  endtask

  task automatic test_ifetch();
    ibus_fetch = 1; ibus_addr = 15'h0010;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL if_c0_req got=%b want=0", mem_req); end
    step();
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 15'h0010}) begin
      failures++; $display("FAIL if_c1 req=%b we=%b addr=%h want 1 0 0010", mem_req, mem_we, mem_addr); end
    mem_ack = 1; mem_rdata = I1_VAL;
    step();
    mem_ack = 0;
    checks++; if ({ibus_done, dbus_done, bus_error, mem_req} !== 4'b1000) begin
      failures++; $display("FAIL if_c2_done got=%b want=1000", {ibus_done, dbus_done, bus_error, mem_req}); end
    checks++; if (ibus_input !== I1_VAL) begin failures++; $display("FAIL if_rdata got=%h want=%h", ibus_input, I1_VAL); end
    ibus_fetch = 0;
    step();
    checks++; if (ibus_done !== 1'b0) begin failures++; $display("FAIL if_c3_pulse got=%b want=0", ibus_done); end
    $display("test_ifetch addr=0010 rdata=%h", ibus_input);
  endtask

  task automatic test_write_wait();
    dbus_write = 1; dbus_addr = 15'h7FFF; dbus_output = 48'hFFFF_FFFF_FFFF;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, dbus_done} !== {2'b11, 15'h7FFF, 48'hFFFF_FFFF_FFFF, 1'b0}) begin
        failures++; $display("FAIL wr_cyc%0d req=%b we=%b addr=%h wdata=%h done=%b", i, mem_req, mem_we, mem_addr, mem_wdata, dbus_done); end
      dbus_output = 48'h0;
      mem_ack = (i == 3);
      step();
    end
    mem_ack = 0;
    checks++; if ({dbus_done, ibus_done, bus_error, mem_req} !== 4'b1000) begin
      failures++; $display("FAIL wr_done got=%b want=1000", {dbus_done, ibus_done, bus_error, mem_req}); end
    checks++; if (dbus_input !== 48'h0 || ibus_input !== I1_VAL) begin
      failures++; $display("FAIL wr_hold dbus=%h ibus=%h want 0 %h", dbus_input, ibus_input, I1_VAL); end
    dbus_write = 0;
    step();
    checks++; if (dbus_done !== 1'b0) begin failures++; $display("FAIL wr_pulse got=%b want=0", dbus_done); end
    $display("test_write_wait addr=7fff 3 wait cycles");
  endtask

  task automatic test_round_robin();
    int dc, ic, dn, inn;
    logic [14:0] first_addr;
    dc = -1; ic = -1; dn = 0; inn = 0; first_addr = '0;
    apply_reset();
    ibus_fetch = 1; ibus_addr = 15'h0020;
    dbus_read = 1; dbus_addr = 15'h0030;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) first_addr = mem_addr;
      if (dbus_done) begin dc = c; dn++; dbus_read = 0; end
      if (ibus_done) begin ic = c; inn++; ibus_fetch = 0; end
      mem_ack = mem_req;
      mem_rdata = (mem_addr == 15'h0030) ? D_VAL : I_VAL;
      step();
    end
    mem_ack = 0;
    checks++; if (first_addr !== 15'h0030) begin failures++; $display("FAIL rr_first got=%h want=0030", first_addr); end
    checks++; if (dc != 2 || ic != 5) begin failures++; $display("FAIL rr_timing dcyc=%0d icyc=%0d want 2 5", dc, ic); end
    checks++; if (dn != 1 || inn != 1) begin failures++; $display("FAIL rr_pulses d=%0d i=%0d want 1 1", dn, inn); end
    checks++; if (dbus_input !== D_VAL || ibus_input !== I_VAL) begin
      failures++; $display("FAIL rr_data dbus=%h ibus=%h want %h %h", dbus_input, ibus_input, D_VAL, I_VAL); end
    $display("test_round_robin dbus_done@%0d ibus_done@%0d", dc, ic);
  endtask

  task automatic test_timeout();
    int req_n, dc, err_n;
    req_n = 0; dc = -1; err_n = 0;
    dbus_read = 1; dbus_addr = 15'h0040; mem_ack = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_req) req_n++;
      if (bus_error) err_n++;
      if (dbus_done) begin
        dc = c; dbus_read = 0;
        checks++; if (bus_error !== 1'b1) begin failures++; $display("FAIL to_err_with_done got=%b want=1", bus_error); end
      end
      step();
    end
    checks++; if (req_n != 4 || dc != 5 || err_n != 1) begin
      failures++; $display("FAIL to_timing req=%0d done@%0d err=%0d want 4 5 1", req_n, dc, err_n); end
    checks++; if (dbus_input !== 48'h0 || ibus_input !== I_VAL) begin
      failures++; $display("FAIL to_data dbus=%h ibus=%h want 0 %h", dbus_input, ibus_input, I_VAL); end
    $display("test_timeout req_cycles=%0d", req_n);
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    ibus_fetch = 1; ibus_addr = 15'h0050;
    step(); step();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rm_access got=%b want=1", mem_req); end
    reset = 1; ibus_fetch = 0;
    step();
    reset = 0; mem_ack = 1; mem_rdata = 48'hDEAD;
    for (int c = 0; c < 3; c++) begin
      if (mem_req || ibus_done || dbus_done || bus_error) bad++;
      step();
    end
    mem_ack = 0;
    checks++; if (bad != 0) begin failures++; $display("FAIL rm_stray got=%0d active cycles want=0", bad); end
    checks++; if ({ibus_input, dbus_input, mem_addr, mem_wdata, mem_we} !== 160'h0) begin
      failures++; $display("FAIL rm_regs ibus=%h dbus=%h addr=%h wdata=%h we=%b", ibus_input, dbus_input, mem_addr, mem_wdata, mem_we); end
    ibus_fetch = 1; ibus_addr = 15'h0060;
    step();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 15'h0060}) begin
      failures++; $display("FAIL rm_next_req req=%b addr=%h want 1 0060", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 48'h1234_5678_9ABC;
    step();
    mem_ack = 0;
    checks++; if (ibus_done !== 1'b1 || ibus_input !== 48'h1234_5678_9ABC) begin
      failures++; $display("FAIL rm_next_done done=%b data=%h want 1 123456789abc", ibus_done, ibus_input); end
    ibus_fetch = 0;
    step();
    $display("test_reset_mid recovered");
  endtask

  task automatic test_rw_both();
    dbus_read = 1; dbus_write = 1; dbus_addr = 15'h0070; dbus_output = 48'h0BAD;
    step();
    checks++; if ({mem_req, mem_we, mem_wdata} !== {2'b11, 48'h0BAD}) begin
      failures++; $display("FAIL rw_we req=%b we=%b wdata=%h want 1 1 0bad", mem_req, mem_we, mem_wdata); end
    mem_ack = 1; mem_rdata = 48'hFFFF;
    step();
    mem_ack = 0;
    checks++; if (dbus_done !== 1'b1 || dbus_input !== 48'h0 || ibus_input !== 48'h1234_5678_9ABC) begin
      failures++; $display("FAIL rw_hold done=%b dbus=%h ibus=%h", dbus_done, dbus_input, ibus_input); end
    dbus_read = 0; dbus_write = 0;
    step();
    $display("test_rw_both treated as write");
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_write_wait();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_rw_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
